// File: rtl/keep_compactor_if.sv
// Lane-stream bundle: valid/ready beat with per-lane keep and lane data.
// The master drives the beat; the slave returns ready.
interface keep_compactor_if #(
  parameter int KEEP_WIDTH   = 2,
  parameter int T_DATA_WIDTH = 4
);
  logic                    valid;
  logic                    ready;
  logic                    last;
  logic [KEEP_WIDTH-1:0]   keep;
  logic [T_DATA_WIDTH-1:0] data [KEEP_WIDTH];

  modport master (output valid, output last, output keep, output data, input ready);
  modport slave  (input valid, input last, input keep, input data, output ready);
endinterface

// File: rtl/keep_compactor.sv
// Removes keep holes and re-packs lanes into full low-aligned beats; partial beats only at packet end.
// Outputs come from registered state only; s_if.ready depends on occupancy, never on m_if.ready.
module keep_compactor #(
  parameter int KEEP_WIDTH   = 2,
  parameter int T_DATA_WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  keep_compactor_if.slave   s_if,
  keep_compactor_if.master  m_if
);
  localparam int DEPTH = 2 * KEEP_WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] KW = CW'(KEEP_WIDTH);

  logic [T_DATA_WIDTH-1:0] lane_q [DEPTH];
  logic [T_DATA_WIDTH-1:0] lane_d [DEPTH];
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    last_pend_q, last_pend_d;

  logic                    full_beat;
  logic                    accept;
  logic                    xfer;
  logic                    m_last;
  logic [KEEP_WIDTH-1:0]   m_keep;
  logic [CW-1:0]           emit_n;
  logic [CW-1:0]           wr_pos;

  always_comb begin
    full_beat = (cnt_q >= KW);
    m_last    = last_pend_q & (cnt_q <= KW);
    m_keep    = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      m_keep[i]    = full_beat | (CW'(i) < cnt_q);
      m_if.data[i] = m_keep[i] ? lane_q[i] : '0;
    end
    m_if.valid = full_beat | last_pend_q;
    m_if.last  = m_last;
    m_if.keep  = m_keep;
    s_if.ready = rst_n & ~last_pend_q & (cnt_q <= KW);
  end

  assign accept = s_if.valid & s_if.ready;
  assign xfer   = m_if.valid & m_if.ready;

  always_comb begin
    emit_n = '0;
    if (xfer) emit_n = full_beat ? KW : cnt_q;

    // Pop emitted lanes: entry j takes the lane emit_n places above it.
    for (int j = 0; j < DEPTH; j++) begin
      lane_d[j] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if (CW'(k) == CW'(j) + emit_n) lane_d[j] = lane_q[k];
      end
    end

    wr_pos = cnt_q - emit_n;
    if (accept) begin
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        if (s_if.keep[i]) begin
          for (int j = 0; j < DEPTH; j++) begin
            if (CW'(j) == wr_pos) lane_d[j] = s_if.data[i];
          end
          wr_pos = wr_pos + CW'(1);
        end
      end
    end
    cnt_d = wr_pos;

    // Accept needs !last_pend and m_last needs last_pend, so these never collide.
    last_pend_d = last_pend_q;
    if (xfer && m_last)        last_pend_d = 1'b0;
    if (accept && s_if.last)   last_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      last_pend_q <= 1'b0;
      for (int j = 0; j < DEPTH; j++) lane_q[j] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      last_pend_q <= last_pend_d;
      for (int j = 0; j < DEPTH; j++) lane_q[j] <= lane_d[j];
    end
  end
endmodule

// File: tb/tb_keep_compactor.sv
// Directed bench for keep_compactor at KEEP_WIDTH=2, T_DATA_WIDTH=4.
module tb_keep_compactor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  keep_compactor_if #(.KEEP_WIDTH(2), .T_DATA_WIDTH(4)) in_if ();
  keep_compactor_if #(.KEEP_WIDTH(2), .T_DATA_WIDTH(4)) out_if ();

  keep_compactor #(.KEEP_WIDTH(2), .T_DATA_WIDTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_if  (in_if),
    .m_if  (out_if)
  );

  logic [7:0] m_pack;
  assign m_pack = {out_if.data[1], out_if.data[0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [3:0] d1,
                       input logic [3:0] d0, input logic l);
    in_if.valid   = v;
    in_if.keep    = k;
    in_if.data[1] = d1;
    in_if.data[0] = d0;
    in_if.last    = l;
  endtask

  task automatic check_beat(input string tag, input logic [1:0] k, input logic [7:0] d,
                            input logic l);
    check({tag, ".valid"}, 32'(out_if.valid), 32'd1);
    check({tag, ".keep"},  32'(out_if.keep),  32'(k));
    check({tag, ".data"},  32'(m_pack),       32'(d));
    check({tag, ".last"},  32'(out_if.last),  32'(l));
  endtask

  initial begin
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    out_if.ready = 1'b1;
    #2;
    check("rst.m_valid", 32'(out_if.valid), 32'd0);
    check("rst.s_ready", 32'(in_if.ready),  32'd0);
    check("rst.m_keep",  32'(out_if.keep),  32'd0);
    check("rst.m_data",  32'(m_pack),       32'd0);
    check("rst.m_last",  32'(out_if.last),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("idle.s_ready", 32'(in_if.ready), 32'd1);

    // 1: full beat passes straight through
    drive(1'b1, 2'b11, 4'h2, 4'h1, 1'b0);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check_beat("t1", 2'b11, 8'h21, 1'b0);
    step();
    check("t1.drain", 32'(out_if.valid), 32'd0);

    // 2: two half beats merge into one
    drive(1'b1, 2'b01, 4'hF, 4'h3, 1'b0);
    step();
    drive(1'b1, 2'b10, 4'h4, 4'hE, 1'b0);
    check("t2.no_early", 32'(out_if.valid), 32'd0);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check_beat("t2", 2'b11, 8'h43, 1'b0);
    step();
    check("t2.drain", 32'(out_if.valid), 32'd0);

    // 3: partial last beat blocks input until it leaves
    out_if.ready = 1'b0;
    drive(1'b1, 2'b01, 4'hA, 4'h5, 1'b1);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check_beat("t3", 2'b01, 8'h05, 1'b1);
    check("t3.s_ready_blk", 32'(in_if.ready), 32'd0);
    step();
    check("t3.s_ready_hold", 32'(in_if.ready), 32'd0);
    check("t3.hold_data", 32'(m_pack), 32'h05);
    out_if.ready = 1'b1;
    step();
    check("t3.drain", 32'(out_if.valid), 32'd0);
    check("t3.s_ready_back", 32'(in_if.ready), 32'd1);

    // 4: odd lane count splits into full beat then last partial beat
    drive(1'b1, 2'b01, 4'h0, 4'h7, 1'b0);
    step();
    drive(1'b1, 2'b11, 4'h9, 4'h8, 1'b1);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check_beat("t4a", 2'b11, 8'h87, 1'b0);
    step();
    check_beat("t4b", 2'b01, 8'h09, 1'b1);
    step();
    check("t4.drain", 32'(out_if.valid), 32'd0);

    // 5: backpressure fills the buffer, then simultaneous accept and transfer
    out_if.ready = 1'b0;
    drive(1'b1, 2'b11, 4'hB, 4'hA, 1'b0);
    step();
    drive(1'b1, 2'b11, 4'hD, 4'hC, 1'b0);
    step();
    check("t5.full_rdy", 32'(in_if.ready), 32'd0);
    drive(1'b1, 2'b11, 4'hF, 4'hE, 1'b0);
    step();
    check("t5.still_full", 32'(in_if.ready), 32'd0);
    check_beat("t5a", 2'b11, 8'hBA, 1'b0);
    out_if.ready = 1'b1;
    step();
    check_beat("t5b", 2'b11, 8'hDC, 1'b0);
    check("t5.rdy_back", 32'(in_if.ready), 32'd1);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check_beat("t5c", 2'b11, 8'hFE, 1'b0);
    step();
    check("t5.drain", 32'(out_if.valid), 32'd0);

    // 6: empty last beat keeps the packet boundary; empty non-last is dropped
    drive(1'b1, 2'b00, 4'h6, 4'h6, 1'b1);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check_beat("t6", 2'b00, 8'h00, 1'b1);
    step();
    check("t6.drain", 32'(out_if.valid), 32'd0);
    drive(1'b1, 2'b00, 4'h6, 4'h6, 1'b0);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check("t6.empty_drop", 32'(out_if.valid), 32'd0);

    // Reset with three lanes buffered drops everything
    out_if.ready = 1'b0;
    drive(1'b1, 2'b11, 4'h2, 4'h1, 1'b0);
    step();
    drive(1'b1, 2'b01, 4'h0, 4'h3, 1'b0);
    step();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    check("rst2.pre_valid", 32'(out_if.valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst2.m_valid", 32'(out_if.valid), 32'd0);
    check("rst2.m_data",  32'(m_pack),       32'd0);
    check("rst2.m_keep",  32'(out_if.keep),  32'd0);
    check("rst2.s_ready", 32'(in_if.ready),  32'd0);
    step();
    rst_n = 1'b1;
    out_if.ready = 1'b1;
    step();
    check("rst2.no_stale", 32'(out_if.valid), 32'd0);
    step();
    check("rst2.no_stale2", 32'(out_if.valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
